// File: rtl/window_minmax_pkg.sv
// Shared types and constants for the windowed min/max tracker.
package window_minmax_pkg;

    localparam int unsigned DW = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    typedef struct packed {
        logic eq;
        logic lt;
        logic gt;
    } cmp_t;

    typedef struct packed {
        logic [DW-1:0] min_v;
        logic [DW-1:0] max_v;
        logic          flat;
    } result_t;

endpackage

// File: rtl/window_minmax_if.sv
// Sample-in / result-out valid/ready bundle for window_minmax.
interface window_minmax_if;

    logic                             in_valid;
    logic [window_minmax_pkg::DW-1:0] in_data;
    logic                             in_ready;
    logic                             out_valid;
    logic                             out_ready;
    logic [window_minmax_pkg::DW-1:0] out_min;
    logic [window_minmax_pkg::DW-1:0] out_max;
    logic                             out_flat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_min, out_max, out_flat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_min, out_max, out_flat
    );

endinterface

// File: rtl/window_minmax_cmp.sv
// Unsigned magnitude comparator producing eq/lt/gt flags for a vs b.
module window_minmax_cmp
    import window_minmax_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output cmp_t          flags_c
);

    assign flags_c.eq = (a == b);
    assign flags_c.lt = (a < b);
    assign flags_c.gt = (a > b);

endmodule

// File: rtl/window_minmax.sv
// Tracks min/max over fixed windows of WINDOW samples and presents
// each window result over a valid/ready handshake.
module window_minmax
    import window_minmax_pkg::*;
#(
    parameter int unsigned WINDOW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    window_minmax_if.slave bus
);

    localparam logic [DW-1:0] LAST_CNT = DW'(WINDOW - 1);

    state_e        state_q;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] acc_min_q;
    logic [DW-1:0] acc_max_q;
    result_t       res_q;

    logic [DW-1:0] nxt_min_c;
    logic [DW-1:0] nxt_max_c;
    cmp_t          cmp_min_c;
    cmp_t          cmp_max_c;
    cmp_t          cmp_flat_c;
    logic          accept_c;
    logic          last_c;
    logic          unused_cmp_c;

    window_minmax_cmp u_cmp_min (
        .a       (bus.in_data),
        .b       (acc_min_q),
        .flags_c (cmp_min_c)
    );

    window_minmax_cmp u_cmp_max (
        .a       (bus.in_data),
        .b       (acc_max_q),
        .flags_c (cmp_max_c)
    );

    // Flatness is judged on the accumulator values including the final sample
    window_minmax_cmp u_cmp_flat (
        .a       (nxt_min_c),
        .b       (nxt_max_c),
        .flags_c (cmp_flat_c)
    );

    assign unused_cmp_c = ^{cmp_min_c.eq, cmp_min_c.gt, cmp_max_c.eq,
                            cmp_max_c.lt, cmp_flat_c.lt, cmp_flat_c.gt};

    assign accept_c = bus.in_valid && (state_q == ACCUM);
    assign last_c   = (cnt_q == LAST_CNT);

    // Accumulator values assuming the current sample is accepted
    always_comb begin
        nxt_min_c = acc_min_q;
        nxt_max_c = acc_max_q;
        if (cnt_q == '0) begin
            nxt_min_c = bus.in_data;
            nxt_max_c = bus.in_data;
        end else begin
            if (cmp_min_c.lt) nxt_min_c = bus.in_data;
            if (cmp_max_c.gt) nxt_max_c = bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            cnt_q     <= '0;
            acc_min_q <= '0;
            acc_max_q <= '0;
            res_q     <= '0;
        end else if (clear) begin
            state_q   <= ACCUM;
            cnt_q     <= '0;
            acc_min_q <= '0;
            acc_max_q <= '0;
            res_q     <= '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept_c) begin
                        acc_min_q <= nxt_min_c;
                        acc_max_q <= nxt_max_c;
                        if (last_c) begin
                            cnt_q       <= '0;
                            res_q.min_v <= nxt_min_c;
                            res_q.max_v <= nxt_max_c;
                            res_q.flat  <= cmp_flat_c.eq;
                            state_q     <= HOLD;
                        end else begin
                            cnt_q <= cnt_q + DW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) state_q <= ACCUM;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_min   = res_q.min_v;
    assign bus.out_max   = res_q.max_v;
    assign bus.out_flat  = res_q.flat;

endmodule

// File: doc/window_minmax.md
Name: window_minmax

Overview:
- Streaming 8-bit sample consumer that uses the 8-bit magnitude comparator to track the minimum and maximum over fixed-size windows of WINDOW samples.
- Sits downstream of the comparator and turns its per-pair eq/lt/gt flags into a windowed result.
- Exposes that result over a valid/ready output handshake.
- Used for sensor peak detection and range checks.

Parameters:
WINDOW, 8, samples per window; legal range 1..255

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort: discard partial window and pending result
in_valid  input  1  sample offered
in_data  input  8  unsigned sample
in_ready  output  1  block accepts sample this cycle
out_valid  output  1  window result available
out_ready  input  1  consumer accepts result
out_min  output  8  minimum of completed window
out_max  output  8  maximum of completed window
out_flat  output  1  1 when out_min == out_max

Behaviour:
Reset (rst_n low, asynchronous, immediate):
- state=ACCUM, cnt=0, acc_min=acc_max=0.
- out_min=out_max=0, out_flat=0, out_valid=0.
- in_ready=1 after reset.

States:
- ACCUM: in_ready=1, out_valid=0.
- HOLD: in_ready=0, out_valid=1.
- in_ready and out_valid are decoded from the state register only. No combinational path from in_valid/out_ready.

Accept rule: a sample is accepted when in_valid & in_ready at the clock edge.

Accumulate:
- Accepted sample with cnt==0: acc_min=acc_max=in_data.
- Accepted sample with cnt>0:
  - acc_min=in_data if comparator(in_data, acc_min).lt.
  - acc_max=in_data if comparator(in_data, acc_max).gt.
  - Ties keep the old value.
- cnt increments by 1 per accepted sample.

Window completion:
- Triggered when the accepted sample has cnt==WINDOW-1.
- out_min/out_max are loaded with the next-state accumulator values, so the final sample is included.
- out_flat is loaded with the eq flag of next acc_min vs next acc_max.
- cnt returns to 0 and state moves to HOLD.
- Latency: out_valid rises the cycle after the last sample is accepted.

HOLD:
- out_min/out_max/out_flat are held stable and in_valid is ignored.
- On out_valid & out_ready: state returns to ACCUM next cycle.
- A new sample cannot be accepted in the handshake cycle, giving a mandatory one-cycle bubble.

Result registers: change only at window completion, clear, or reset. They hold their value across the following ACCUM period.

WINDOW=1: every accepted sample produces a result with out_flat=1.

clear:
- Priority over all in-cycle events: a sample accepted in the same cycle is discarded, and a result handshake in the same cycle is ignored.
- Next state is ACCUM with cnt=0, out_valid=0, and out_min/out_max/out_flat zeroed.

in_valid while in HOLD: no effect. The upstream must hold the sample; the protocol is standard valid/ready.

Arithmetic: unsigned 8-bit compares only, no wrap concerns. cnt is 8 bits and never exceeds WINDOW-1.

Decomposition:
- Shared package holds the state encoding constants (ACCUM=1'b0, HOLD=1'b1) and the data width constant DW=8.
- The existing 8-bit comparator is instantiated twice as the natural sub-module: one instance for sample vs acc_min, one for sample vs acc_max.
- A third compare for out_flat reuses the comparator on next acc_min vs next acc_max.
- No other sub-modules.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> out_valid=0, out_min=0, out_max=0, out_flat=0 immediately; in_ready=1 after release.
- WINDOW=4, samples 5,3,9,3 back-to-back, out_ready=1 -> out_valid high exactly 1 cycle after 4th accept; out_min=3, out_max=9, out_flat=0; in_ready=0 that cycle.
- Backpressure: hold out_ready=0 for 5 cycles while driving in_valid=1, in_data=0x77 -> out_valid, out_min, out_max stable, no sample accepted. Raise out_ready, then send 0xFF x4 -> out_min=out_max=0xFF, out_flat=1.
- clear: accept 200,10, pulse clear together with a third sample 0 -> sample dropped. Then send 50,60,70,80 -> out_min=50, out_max=80.
- Nibble boundaries: samples 0x10,0x01,0x0F,0xF0 -> out_min=0x01, out_max=0xF0. Follow with 0x00,0xFF,0xFF,0x00 -> out_min=0x00, out_max=0xFF.
- Reset mid-operation: assert rst_n low after 2 samples of a window and again while out_valid=1. Each time the partial or pending result is lost and outputs return to zero. The next full window of 4,4,4,4 -> out_min=out_max=4, out_flat=1.
